// File: rtl/mem_access_unit_pkg.sv
// Shared processor definitions for the memory-stage access unit, the control
// unit and the data memory.
package mem_access_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 16;
  localparam int REG_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_SECOND  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_EXC     = 3'd5
  } mau_state_t;

  // Bit 1 = double-word, bit 0 = write.
  typedef enum logic [1:0] {
    ACC_SINGLE_READ  = 2'b00,
    ACC_SINGLE_WRITE = 2'b01,
    ACC_DOUBLE_READ  = 2'b10,
    ACC_DOUBLE_WRITE = 2'b11
  } mau_kind_t;

  function automatic mau_kind_t make_kind(input logic dbl, input logic wr);
    return mau_kind_t'({dbl, wr});
  endfunction

  // Conflicting direction, or a double-word op naming an odd register.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic dbl, input logic reg_lsb);
    return (rd && wr) || (dbl && reg_lsb);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the memory access unit.
// slave: the access unit. master: control unit plus data memory.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                 req_read;
  logic                 req_write;
  logic                 req_double;
  logic [REG_IDX_W-1:0] req_reg;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata0;
  logic [DATA_W-1:0]    req_wdata1;
  logic                 busy;
  logic                 done;
  logic                 exception;
  logic                 second_cycle;
  logic [DATA_W-1:0]    rdata0;
  logic [DATA_W-1:0]    rdata1;
  logic [ADDR_W-1:0]    dmem_addr;
  logic                 dmem_re;
  logic                 dmem_we;
  logic [DATA_W-1:0]    dmem_wdata;
  logic [DATA_W-1:0]    dmem_rdata;

  modport slave (
    input  req_read, req_write, req_double, req_reg, req_addr,
           req_wdata0, req_wdata1, dmem_rdata,
    output busy, done, exception, second_cycle, rdata0, rdata1,
           dmem_addr, dmem_re, dmem_we, dmem_wdata
  );

  modport master (
    output req_read, req_write, req_double, req_reg, req_addr,
           req_wdata0, req_wdata1, dmem_rdata,
    input  busy, done, exception, second_cycle, rdata0, rdata1,
           dmem_addr, dmem_re, dmem_we, dmem_wdata
  );

endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: sequences one or two word accesses to the
// synchronous data memory for LW/SW/LDW/SDW and reports done/exception.
//
// state   | meaning
// IDLE    | waiting for a request; only state that samples req_*
// FIRST   | first word access at base address
// SECOND  | second word access at base+1 (double ops only)
// CAPTURE | last read word returns from memory, no strobes
// DONE    | one-cycle completion pulse
// EXC     | illegal request, done+exception pulse, no memory access
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  mau_state_t        state, state_next;
  mau_kind_t         kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata0_q;
  logic [DATA_W-1:0] wdata1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              req_any;
  logic              is_write;
  logic              is_double;

  assign req_any   = bus.req_read || bus.req_write;
  assign is_write  = kind_q[0];
  assign is_double = kind_q[1];

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Capture the request in IDLE so the requester need not hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q   <= ACC_SINGLE_READ;
      addr_q   <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else if (state == ST_IDLE && req_any) begin
      kind_q   <= make_kind(bus.req_double, bus.req_write);
      addr_q   <= bus.req_addr;
      wdata0_q <= bus.req_wdata0;
      wdata1_q <= bus.req_wdata1;
    end
  end

  // Load-data registers; a single load leaves rdata1 untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == ST_SECOND && !is_write) begin
      rdata0_q <= bus.dmem_rdata;
    end else if (state == ST_CAPTURE) begin
      if (is_double) rdata1_q <= bus.dmem_rdata;
      else           rdata0_q <= bus.dmem_rdata;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next       = state;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.exception    = 1'b0;
    bus.second_cycle = 1'b0;
    bus.dmem_addr    = '0;
    bus.dmem_re      = 1'b0;
    bus.dmem_we      = 1'b0;
    bus.dmem_wdata   = '0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          if (is_illegal(bus.req_read, bus.req_write, bus.req_double, bus.req_reg[0]))
            state_next = ST_EXC;
          else
            state_next = ST_FIRST;
        end
      end
      ST_FIRST: begin
        bus.busy       = 1'b1;
        bus.dmem_addr  = addr_q;
        bus.dmem_re    = !is_write;
        bus.dmem_we    = is_write;
        bus.dmem_wdata = wdata0_q;
        if (is_double)     state_next = ST_SECOND;
        else if (is_write) state_next = ST_DONE;
        else               state_next = ST_CAPTURE;
      end
      ST_SECOND: begin
        bus.busy         = 1'b1;
        bus.second_cycle = 1'b1;
        bus.dmem_addr    = addr_q + ADDR_W'(1);
        bus.dmem_re      = !is_write;
        bus.dmem_we      = is_write;
        bus.dmem_wdata   = wdata1_q;
        state_next       = is_write ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        bus.busy   = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_EXC: begin
        bus.done      = 1'b1;
        bus.exception = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1-cycle-latency RAM model and a
// scoreboard of expected completions.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory, one-cycle read latency; counts strobes.
  logic [31:0] mem [0:65535];
  int strobe_cnt = 0;
  always @(posedge clk) begin
    if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
    if (bus.dmem_re) bus.dmem_rdata <= mem[bus.dmem_addr];
    if (bus.dmem_re || bus.dmem_we) strobe_cnt <= strobe_cnt + 1;
  end

  typedef struct {
    int          t0;
    int          lat;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          t_issue = 0;
  int          s0 = 0;
  logic [31:0] m_r0 = '0;
  logic [31:0] m_r1 = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_exc"}, bus.exception, 0);
    chk({tag, "_second"}, bus.second_cycle, 0);
    chk({tag, "_re"}, bus.dmem_re, 0);
    chk({tag, "_we"}, bus.dmem_we, 0);
    chk({tag, "_addr"}, bus.dmem_addr, 0);
    chk({tag, "_wdata"}, bus.dmem_wdata, 0);
  endtask

  // Present a request for one cycle, then scramble the inputs to show
  // they are not needed after the sampling edge.
  task automatic issue(input logic rd, input logic wr, input logic dbl,
                       input logic [3:0] rg, input logic [15:0] a,
                       input logic [31:0] w0, input logic [31:0] w1);
    bus.req_read   = rd;
    bus.req_write  = wr;
    bus.req_double = dbl;
    bus.req_reg    = rg;
    bus.req_addr   = a;
    bus.req_wdata0 = w0;
    bus.req_wdata1 = w1;
    t_issue = cyc;
    tick();
    bus.req_read   = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_double = ~dbl;
    bus.req_reg    = ~rg;
    bus.req_addr   = 16'hBAD0;
    bus.req_wdata0 = $urandom;
    bus.req_wdata1 = $urandom;
  endtask

  task automatic expect_done(input int lat, input logic exc);
    exp_t e;
    e.t0 = t_issue; e.lat = lat; e.r0 = m_r0; e.r1 = m_r1; e.exc = exc;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done, compare against the oldest expectation,
  // then step into IDLE.
  task automatic complete(input string tag);
    exp_t e;
    int n = 0;
    while (bus.done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, bus.done, 1);
    chk({tag, "_sb_pending"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc - e.t0, e.lat);
      chk({tag, "_exception"}, bus.exception, e.exc);
      chk({tag, "_busy_at_done"}, bus.busy, 0);
      chk({tag, "_rdata0"}, bus.rdata0, e.r0);
      chk({tag, "_rdata1"}, bus.rdata1, e.r1);
    end
    tick();
    chk({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.req_read = 0; bus.req_write = 0; bus.req_double = 0; bus.req_reg = 0;
    bus.req_addr = 0; bus.req_wdata0 = 0; bus.req_wdata1 = 0;
    tick(); tick();
    chk_quiet("rst");
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);
    reset = 1'b0;
    tick();

    // SW
    issue(0, 1, 0, 4'd1, 16'h0010, 32'hDEADBEEF, 32'h0);
    expect_done(2, 0);
    chk("sw_t1_we", bus.dmem_we, 1);
    chk("sw_t1_re", bus.dmem_re, 0);
    chk("sw_t1_busy", bus.busy, 1);
    chk("sw_t1_addr", bus.dmem_addr, 16'h0010);
    chk("sw_t1_wdata", bus.dmem_wdata, 32'hDEADBEEF);
    complete("sw");
    chk("sw_ram", mem[16'h0010], 32'hDEADBEEF);

    // SDW reg 4
    issue(0, 1, 1, 4'd4, 16'h0020, 32'h11111111, 32'h22222222);
    expect_done(3, 0);
    chk("sdw_t1_we", bus.dmem_we, 1);
    chk("sdw_t1_addr", bus.dmem_addr, 16'h0020);
    chk("sdw_t1_wdata", bus.dmem_wdata, 32'h11111111);
    chk("sdw_t1_second", bus.second_cycle, 0);
    tick();
    chk("sdw_t2_we", bus.dmem_we, 1);
    chk("sdw_t2_addr", bus.dmem_addr, 16'h0021);
    chk("sdw_t2_wdata", bus.dmem_wdata, 32'h22222222);
    chk("sdw_t2_second", bus.second_cycle, 1);
    complete("sdw");
    chk("sdw_ram0", mem[16'h0020], 32'h11111111);
    chk("sdw_ram1", mem[16'h0021], 32'h22222222);

    // LDW reg 6
    issue(1, 0, 1, 4'd6, 16'h0020, 32'h0, 32'h0);
    m_r0 = 32'h11111111; m_r1 = 32'h22222222;
    expect_done(4, 0);
    chk("ldw_t1_re", bus.dmem_re, 1);
    chk("ldw_t1_addr", bus.dmem_addr, 16'h0020);
    tick();
    chk("ldw_t2_re", bus.dmem_re, 1);
    chk("ldw_t2_addr", bus.dmem_addr, 16'h0021);
    chk("ldw_t2_second", bus.second_cycle, 1);
    tick();
    chk("ldw_t3_busy", bus.busy, 1);
    chk("ldw_t3_re", bus.dmem_re, 0);
    chk("ldw_t3_addr", bus.dmem_addr, 0);
    complete("ldw");

    // LW: rdata1 must keep the LDW second word
    issue(1, 0, 0, 4'd3, 16'h0010, 32'h0, 32'h0);
    m_r0 = 32'hDEADBEEF;
    expect_done(3, 0);
    chk("lw_t1_re", bus.dmem_re, 1);
    chk("lw_t1_busy", bus.busy, 1);
    chk("lw_t1_addr", bus.dmem_addr, 16'h0010);
    tick();
    chk("lw_t2_busy", bus.busy, 1);
    chk("lw_t2_re", bus.dmem_re, 0);
    complete("lw");

    // Illegal requests
    s0 = strobe_cnt;
    issue(1, 0, 1, 4'd5, 16'h0020, 32'h0, 32'h0);
    expect_done(1, 1);
    complete("exc_ldw_odd");
    issue(0, 1, 1, 4'd9, 16'h0030, 32'h99999999, 32'h88888888);
    expect_done(1, 1);
    complete("exc_sdw_odd");
    issue(1, 1, 0, 4'd2, 16'h0030, 32'h77777777, 32'h0);
    expect_done(1, 1);
    complete("exc_rw");
    chk("exc_no_strobes", strobe_cnt, s0);

    // Wrap at top of memory: store then load the pair at 0xFFFF
    issue(0, 1, 1, 4'd2, 16'hFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A);
    expect_done(3, 0);
    chk("wsdw_t1_addr", bus.dmem_addr, 16'hFFFF);
    tick();
    chk("wsdw_t2_addr", bus.dmem_addr, 16'h0000);
    complete("wsdw");
    chk("wsdw_ram0", mem[16'h0000], 32'h5A5A5A5A);

    s0 = strobe_cnt;
    issue(1, 0, 1, 4'd2, 16'hFFFF, 32'h0, 32'h0);
    m_r0 = 32'hA5A5A5A5; m_r1 = 32'h5A5A5A5A;
    expect_done(4, 0);
    chk("wldw_t1_addr", bus.dmem_addr, 16'hFFFF);
    bus.req_write = 1'b1; bus.req_addr = 16'h0040; bus.req_wdata0 = 32'hCAFEF00D;
    tick();
    chk("wldw_t2_addr", bus.dmem_addr, 16'h0000);
    chk("wldw_t2_re", bus.dmem_re, 1);
    chk("wldw_t2_we", bus.dmem_we, 0);
    tick();
    chk("wldw_t3_we", bus.dmem_we, 0);
    tick();
    bus.req_write = 1'b0;
    complete("wldw");
    tick(); tick();
    chk("wldw_strobes", strobe_cnt, s0 + 2);
    chk("wldw_idle_busy", bus.busy, 0);

    // Reset during SECOND of an SDW
    issue(0, 1, 1, 4'd0, 16'h0050, 32'h33333333, 32'h44444444);
    chk("rsdw_t1_we", bus.dmem_we, 1);
    tick();
    chk("rsdw_t2_second", bus.second_cycle, 1);
    reset = 1'b1;
    tick();
    m_r0 = '0; m_r1 = '0;
    chk_quiet("rmid");
    chk("rmid_rdata0", bus.rdata0, 0);
    chk("rmid_rdata1", bus.rdata1, 0);
    s0 = strobe_cnt;
    reset = 1'b0;
    tick(); tick();
    chk("rmid_no_strobes", strobe_cnt, s0);

    issue(1, 0, 0, 4'd1, 16'h0020, 32'h0, 32'h0);
    m_r0 = 32'h11111111;
    expect_done(3, 0);
    complete("post_rst_lw");

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Responder for the control unit's memory-stage requests: LW, SW, LDW (double-word load) and SDW (double-word store).
- Sequences one or two word accesses to the synchronous data memory.
- Raises the exception flag the control unit samples for odd-register double-word ops.
- Drives busy (the control unit's stall source), then pulses done with the read data.

Parameters:
DATA_W, 32, data word width
ADDR_W, 16, word-address width of data memory
REG_IDX_W, 4, width of destination/source register index

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
req_read  in  1  load request (LW/LDW), sampled in IDLE only
req_write  in  1  store request (SW/SDW), sampled in IDLE only
req_double  in  1  1 = LDW/SDW, 0 = LW/SW
req_reg  in  REG_IDX_W  Rd (load) / Rs (store) index, checked for parity on double ops
req_addr  in  ADDR_W  word base address
req_wdata0  in  DATA_W  store word 0
req_wdata1  in  DATA_W  store word 1 (double only)
busy  out  1  access in progress (stall)
done  out  1  one-cycle completion pulse
exception  out  1  one-cycle pulse, coincident with done, on an illegal request
second_cycle  out  1  high while the second word is being accessed
rdata0  out  DATA_W  loaded word 0
rdata1  out  DATA_W  loaded word 1
dmem_addr  out  ADDR_W  memory address
dmem_re  out  1  memory read strobe; data returned on dmem_rdata the next cycle
dmem_we  out  1  memory write strobe
dmem_wdata  out  DATA_W  memory write data
dmem_rdata  in  DATA_W  memory read data, 1-cycle latency

Behaviour:
- Reset values: all outputs 0, state IDLE, rdata0 and rdata1 cleared.
- Reset mid-operation aborts immediately. No dmem_re/dmem_we is issued in the cycle after reset is sampled.
- FSM states: IDLE, FIRST, SECOND, CAPTURE, DONE, EXC.
- IDLE, cycle T, with req_read or req_write set:
  - Latch addr, wdata0, wdata1, reg, kind.
  - Illegal request goes to EXC: req_read and req_write both set, or req_double=1 with req_reg[0]=1.
  - Otherwise go to FIRST.
- Requests are ignored outside IDLE. Inputs need not be held after T.
- FIRST (T+1): busy=1, dmem_addr=base, dmem_re=read, dmem_we=write, dmem_wdata=wdata0.
  - Next state: SECOND if double; CAPTURE if single read; DONE if single write.
- SECOND: busy=1, second_cycle=1, dmem_addr=base+1 (wraps modulo 2^ADDR_W), dmem_wdata=wdata1.
  - For reads, rdata0 is loaded from dmem_rdata at the end of this cycle.
  - Next state: CAPTURE if read, DONE if write.
- CAPTURE: busy=1, no strobes. Loads rdata0 (single) or rdata1 (double) from dmem_rdata. Next state DONE.
- DONE: done=1, busy=0. Next state IDLE. A new request is accepted only in IDLE, so it is accepted no earlier than the cycle after DONE.
- EXC: exception=1, done=1, busy=0, no memory strobes. rdata0/rdata1 unchanged. Next state IDLE.
- Latency from request cycle T to done:
  - SW: T+2
  - LW: T+3
  - SDW: T+3
  - LDW: T+4
  - exception: T+1
- rdata0 and rdata1 hold their values until overwritten by a later load. A single-word load does not modify rdata1.
- dmem_addr and dmem_wdata are 0 whenever no strobe is active.

Decomposition:
- Shared processor package holds:
  - the state enum (mau_state_t)
  - the access-kind enum (single/double × read/write)
  - DATA_W/ADDR_W defaults, shared with control_unit and data memory
- No sub-module. The FSM and the address/data registers live in one module.
- The bench uses a behavioural 1-cycle-latency RAM model.

Test Plan:
- SW, addr=0x0010, wdata0=0xDEADBEEF -> dmem_we=1 at T+1 with addr 0x0010; done at T+2; busy high only at T+1; RAM[0x10]=0xDEADBEEF.
- LW from addr 0x0010 (RAM=0xDEADBEEF) -> dmem_re at T+1; busy at T+1..T+2; done at T+3 with rdata0=0xDEADBEEF; rdata1 unchanged.
- SDW reg=4, addr=0x0020, data 0x11111111/0x22222222 -> writes at T+1 (0x20) and T+2 (0x21, second_cycle=1); done at T+3. Then LDW reg=6 at 0x20 -> done at T+4, rdata0=0x11111111, rdata1=0x22222222.
- LDW with reg=5 -> exception=1 and done=1 at T+1; no dmem strobes at all; rdata unchanged. Same check for SDW reg=9, and for req_read=req_write=1.
- LDW at addr=0xFFFF -> second access at addr 0x0000 (wrap); a new request asserted during busy is ignored, and no extra access follows done.
- reset asserted in SECOND of an SDW -> at the next edge all outputs are 0 and state is IDLE; no further dmem_we; a new LW issued after reset completes normally.
